fd_pipe_reg: RTL
================

Name: fd_pipe_reg

Overview:
- Fetch/Decode pipeline register. It sits directly downstream of the fetch unit.
- It captures the fetched PC and instruction each cycle and presents them to the Decode stage.
- It returns the PC write-enable to the fetch unit and implements hazard stall, flush-to-bubble and fetch address-error detection.
- An optional set of pipeline performance counters can be compiled in.

Parameters:
- PC_RESET, 32'h0000_3000, PC value held in D_PC after reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFC, highest legal word-aligned fetch address (inclusive).
- EXC_ADEL, 5'd4, exception code for an instruction-fetch address error.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- F_PC  in  32  PC of the instruction currently in Fetch.
- F_Instr  in  32  instruction word from instruction memory.
- STALL  in  1  from the hazard unit; hold Decode and Fetch.
- FLUSH  in  1  from the exception/redirect logic; turn Decode into a bubble.
- F_WE  out  1  PC write-enable to the fetch unit.
- D_PC  out  32  registered PC.
- D_PC8  out  32  D_PC + 8, the link address.
- D_Instr  out  32  registered instruction; 0 (nop) when not valid.
- D_Valid  out  1  1 when the Decode slot holds a real instruction.
- D_ExcCode  out  5  0 = none; EXC_ADEL = fetch address error.
- PERF_CYC  out  32  cycle counter (optional feature).
- PERF_ISSUE  out  32  valid-load counter (optional feature).
- PERF_STALL  out  32  stall-cycle counter (optional feature).

Behaviour:
- Reset state: D_PC=PC_RESET, D_Instr=0, D_Valid=0, D_ExcCode=0, all PERF_* = 0.
- Slot state machine, state is D_Valid: EMPTY (0) / FULL (1). Per posedge, the first matching rule wins:
  1. RESET: go to EMPTY with the reset values above. This applies even mid-stall or mid-flush.
  2. FLUSH (regardless of STALL): go to EMPTY. D_Instr=0, D_ExcCode=0, D_PC <= F_PC so the bubble carries the PC for exception tracking.
  3. STALL: all D_* registers hold; state unchanged (a stalled EMPTY stays EMPTY).
  4. Otherwise load: D_PC <= F_PC and go to FULL.
     - If F_PC is legal: D_Instr <= F_Instr, D_ExcCode <= 0.
     - If F_PC is illegal: D_Instr <= 0, D_ExcCode <= EXC_ADEL, D_Valid <= 1. The slot stays FULL so the exception reaches the commit point.
- Legality of F_PC:
  - Illegal if F_PC[1:0] != 0, or F_PC < IM_BASE, or F_PC > IM_LIMIT.
  - Compare as unsigned 32-bit values; addresses that wrap past 32'hFFFF_FFFC are illegal.
- F_WE (combinational): F_WE = ~STALL | FLUSH.
  - On a flush the fetch unit must accept the redirect NPC even while STALL is asserted.
  - Forced to 1 while RESET is asserted.
- D_PC8 (combinational): D_PC + 32'd8, modulo 2^32. It is computed for bubbles too.
- Latency: one cycle from F_PC/F_Instr to D_*. There is no internal buffering beyond the single slot.
- STALL and FLUSH high in the same cycle: FLUSH wins (rule 2) and F_WE=1.

Optional Feature:
- Macro FD_PERF_CNT_EN.
- When defined, three 32-bit counters are cleared by RESET and wrap at 2^32:
  - PERF_CYC increments every non-reset cycle.
  - PERF_ISSUE increments on every rule-4 load (legal or not).
  - PERF_STALL increments on every rule-3 cycle.
- When undefined: the counter flops are not generated, the PERF_* ports stay present, and they are tied to 32'd0.

Decomposition:
- Shared pipeline package/header holds:
  - PC_RESET, IM_BASE and IM_LIMIT, shared with the fetch unit.
  - The exception-code constants (EXC_NONE=0, EXC_ADEL=4).
  - The NOP constant 32'h0.
- One natural sub-module: fd_perf_cnt, the three counters behind FD_PERF_CNT_EN, with inputs inc_cyc, inc_issue and inc_stall.
- Address-legality check stays inline as combinational logic.

Test Plan:
- Reset: RESET=1 for 2 cycles with F_PC=32'h3004, F_Instr=32'h3C01_1234 -> D_PC=32'h3000, D_Instr=0, D_Valid=0, D_ExcCode=0, F_WE=1, PERF_*=0.
- Normal flow: 4 consecutive cycles with F_PC=32'h3000/3004/3008/300C and distinct instructions -> each appears on D_* one cycle later, D_Valid=1, D_PC8=D_PC+8; PERF_ISSUE=4 with the macro, 0 without.
- Stall: STALL=1 for 3 cycles while D holds (32'h3008, 32'h8C22_0000) -> D_* unchanged, F_WE=0, PERF_STALL=3. On release, the next F_PC loads.
- Flush during stall: STALL=1 and FLUSH=1 with F_PC=32'h4180 -> F_WE=1; next cycle D_Valid=0, D_Instr=0, D_PC=32'h4180, D_ExcCode=0.
- Address error: F_PC=32'h3002, then 32'h2FFC, then 32'h7000 -> each gives D_ExcCode=4, D_Instr=0, D_Valid=1. F_PC=32'h6FFC loads normally.
- Reset mid-stall: STALL=1 with D full, then RESET=1 for one cycle -> D returns to reset values next cycle regardless of STALL.

Source files
------------

// File: rtl/fd_pipe_reg_pkg.sv
// Shared Fetch/Decode constants: reset PC, instruction-memory window, exception codes, NOP.
package fd_pipe_reg_pkg;

  localparam logic [31:0] FD_PC_RESET = 32'h0000_3000;
  localparam logic [31:0] FD_IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] FD_IM_LIMIT = 32'h0000_6FFC;

  localparam logic [4:0]  FD_EXC_NONE = 5'd0;
  localparam logic [4:0]  FD_EXC_ADEL = 5'd4;

  localparam logic [31:0] FD_NOP = 32'h0;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/fd_pipe_reg_if.sv
// Fetch/Decode handshake bundle: fetch-side inputs, PC write-enable and Decode-side outputs.
interface fd_pipe_reg_if;

  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        STALL;
  logic        FLUSH;
  logic        F_WE;
  logic [31:0] D_PC;
  logic [31:0] D_PC8;
  logic [31:0] D_Instr;
  logic        D_Valid;
  logic [4:0]  D_ExcCode;

  modport master (
    output F_PC, F_Instr, STALL, FLUSH,
    input  F_WE, D_PC, D_PC8, D_Instr, D_Valid, D_ExcCode
  );

  modport slave (
    input  F_PC, F_Instr, STALL, FLUSH,
    output F_WE, D_PC, D_PC8, D_Instr, D_Valid, D_ExcCode
  );

endinterface

// File: rtl/fd_perf_cnt.sv
// Fetch/Decode performance counters (cycles, issues, stalls); used only when FD_PERF_CNT_EN is defined.
module fd_perf_cnt (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        inc_cyc,
  input  logic        inc_issue,
  input  logic        inc_stall,
  output logic [31:0] cyc,
  output logic [31:0] issue,
  output logic [31:0] stall
);

  logic [31:0] cyc_q, cyc_d;
  logic [31:0] issue_q, issue_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    cyc_d   = cyc_q;
    issue_d = issue_q;
    stall_d = stall_q;
    if (RESET) begin
      cyc_d   = '0;
      issue_d = '0;
      stall_d = '0;
    end else begin
      if (inc_cyc)   cyc_d   = cyc_q + 32'd1;
      if (inc_issue) issue_d = issue_q + 32'd1;
      if (inc_stall) stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    cyc_q   <= cyc_d;
    issue_q <= issue_d;
    stall_q <= stall_d;
  end

  assign cyc   = cyc_q;
  assign issue = issue_q;
  assign stall = stall_q;

endmodule

// File: rtl/fd_pipe_reg.sv
// Fetch/Decode pipeline register with stall, flush-to-bubble and fetch address-error tagging.
// Define FD_PERF_CNT_EN to build the PERF_* counters; otherwise those ports read zero.
module fd_pipe_reg
  import fd_pipe_reg_pkg::*;
#(
  parameter logic [31:0] PC_RESET = FD_PC_RESET,
  parameter logic [31:0] IM_BASE  = FD_IM_BASE,
  parameter logic [31:0] IM_LIMIT = FD_IM_LIMIT,
  parameter logic [4:0]  EXC_ADEL = FD_EXC_ADEL
) (
  input  logic               CLK,
  input  logic               RESET,
  fd_pipe_reg_if.slave       bus,
  output logic [31:0]        PERF_CYC,
  output logic [31:0]        PERF_ISSUE,
  output logic [31:0]        PERF_STALL
);

  slot_e       slot_q, slot_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  exc_q, exc_d;
  logic        addr_err;

  assign addr_err = (bus.F_PC[1:0] != 2'b00) || (bus.F_PC < IM_BASE) || (bus.F_PC > IM_LIMIT);

  // Priority: reset, flush (bubble keeps F_PC), stall (hold), load.
  always_comb begin
    slot_d  = slot_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    exc_d   = exc_q;
    if (RESET) begin
      slot_d  = SLOT_EMPTY;
      pc_d    = PC_RESET;
      instr_d = FD_NOP;
      exc_d   = FD_EXC_NONE;
    end else if (bus.FLUSH) begin
      slot_d  = SLOT_EMPTY;
      pc_d    = bus.F_PC;
      instr_d = FD_NOP;
      exc_d   = FD_EXC_NONE;
    end else if (!bus.STALL) begin
      slot_d  = SLOT_FULL;
      pc_d    = bus.F_PC;
      instr_d = addr_err ? FD_NOP : bus.F_Instr;
      exc_d   = addr_err ? EXC_ADEL : FD_EXC_NONE;
    end
  end

  always_ff @(posedge CLK) begin
    slot_q  <= slot_d;
    pc_q    <= pc_d;
    instr_q <= instr_d;
    exc_q   <= exc_d;
  end

  assign bus.F_WE      = RESET | ~bus.STALL | bus.FLUSH;
  assign bus.D_PC      = pc_q;
  assign bus.D_PC8     = pc_q + 32'd8;
  assign bus.D_Instr   = instr_q;
  assign bus.D_Valid   = (slot_q == SLOT_FULL);
  assign bus.D_ExcCode = exc_q;

`ifdef FD_PERF_CNT_EN
  logic inc_issue, inc_stall;

  assign inc_issue = ~RESET & ~bus.FLUSH & ~bus.STALL;
  assign inc_stall = ~RESET & ~bus.FLUSH &  bus.STALL;

  fd_perf_cnt u_perf (
    .CLK       (CLK),
    .RESET     (RESET),
    .inc_cyc   (~RESET),
    .inc_issue (inc_issue),
    .inc_stall (inc_stall),
    .cyc       (PERF_CYC),
    .issue     (PERF_ISSUE),
    .stall     (PERF_STALL)
  );
`else
  assign PERF_CYC   = '0;
  assign PERF_ISSUE = '0;
  assign PERF_STALL = '0;
`endif

endmodule
